// File: rtl/fpu_pkg.sv
// Shared FPU constants: converter latency, default tag width and a pointer-width helper.
package fpu_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned ITOF_LAT  = 3;
  localparam int unsigned ITOF_TAGW = 6;

  // Index width for a storage of n entries (never zero).
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with count; storage is unreset, pointers/count reset synchronously.
module fifo_sync
  import fpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = ptr_w(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/itof_issue.sv
// Issue/collect wrapper for a fixed-latency int-to-float converter: tag pipeline,
// credit-based admission and an in-order result FIFO.
module itof_issue
  import fpu_pkg::*;
#(
  parameter int unsigned LAT   = ITOF_LAT,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAGW  = ITOF_TAGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_x,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     cvt_x,
  input  logic [31:0]     cvt_y,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_y,
  output logic [TAGW-1:0] res_tag,
  output logic            busy
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = AW + 2;
  localparam int unsigned EW = FP_W + TAGW;

  logic [LAT-1:0]  vld;
  logic [TAGW-1:0] tag_pipe [LAT];
  logic            accept;
  logic [OW-1:0]   inflight;
  logic [OW-1:0]   occupancy;
  logic            fifo_pop;
  logic [EW-1:0]   fifo_wdata;
  logic [EW-1:0]   fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign cvt_x = req_x;

  // Every in-flight conversion holds a reserved FIFO slot, so admission never overflows.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(LAT); i++) begin
      inflight = inflight + OW'(vld[i]);
    end
  end

  assign occupancy = OW'(fifo_count) + inflight;
  assign req_ready = !rst && !fifo_full && (occupancy < OW'(DEPTH));
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= accept;
      for (int i = 1; i < int'(LAT); i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_pipe[0] <= req_tag;
    for (int i = 1; i < int'(LAT); i++) begin
      tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign fifo_wdata = {cvt_y, tag_pipe[LAT-1]};
  assign fifo_pop   = res_valid && res_ready;

  fifo_sync #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (vld[LAT-1]),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign res_valid        = !rst && !fifo_empty;
  assign {res_y, res_tag} = fifo_rdata;
  assign busy             = !rst && ((|vld) || !fifo_empty);

endmodule

// File: tb/tb_itof_issue.sv
// Directed/random bench for itof_issue with a behavioural 3-cycle converter and result scoreboard.
module tb_itof_issue;

  typedef struct packed {
    logic [31:0] y;
    logic [5:0]  tag;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [31:0] req_x = '0;
  logic [5:0]  req_tag = '0;
  logic        req_ready;
  logic [31:0] cvt_x;
  logic [31:0] cvt_y;
  logic        res_valid;
  logic [31:0] res_y;
  logic [5:0]  res_tag;
  logic        busy;

  ent_t sb[$];
  ent_t got[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  logic prev_stall = 1'b0;
  ent_t prev_e;
  logic [31:0] cv [3];
  logic [31:0] xs [4];
  logic [31:0] ys [4];

  always #5 clk = ~clk;

  itof_issue dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_tag  (req_tag),
    .cvt_x    (cvt_x),
    .cvt_y    (cvt_y),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_y    (res_y),
    .res_tag  (res_tag),
    .busy     (busy)
  );

  // Signed int32 to binary32, round to nearest even.
  function automatic logic [31:0] itof(input logic [31:0] x);
    logic        s;
    logic [31:0] m;
    logic [31:0] norm;
    logic [24:0] man;
    logic [7:0]  e;
    int          msb;
    if (x == 32'd0) return 32'd0;
    s   = x[31];
    m   = s ? (~x + 32'd1) : x;
    msb = 31;
    while (!m[msb]) msb--;
    e    = 8'(127 + msb);
    norm = m << (31 - msb);
    man  = {1'b0, norm[31:8]};
    if (norm[7] && ((|norm[6:0]) || norm[8])) man = man + 25'd1;
    if (man[24]) begin
      man = man >> 1;
      e   = e + 8'd1;
    end
    return {s, e, man[22:0]};
  endfunction

  // Converter held in reset alongside the issue block.
  always @(posedge clk) begin
    if (rst) begin
      cv[0] <= '0;
      cv[1] <= '0;
      cv[2] <= '0;
    end else begin
      cv[0] <= itof(cvt_x);
      cv[1] <= cv[0];
      cv[2] <= cv[1];
    end
  end
  assign cvt_y = cv[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: record accepts, retire results, check head stability and FIFO bounds.
  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        sb.push_back('{y: itof(req_x), tag: req_tag});
        n_acc++;
      end
      if (dut.u_fifo.push) begin
        chk("fifo_overflow", 64'(dut.u_fifo.full), 64'd0);
        chk("count_bound", 64'(dut.u_fifo.count <= 4'd8), 64'd1);
      end
      if (prev_stall) begin
        chk("stall_y", 64'(res_y), 64'(prev_e.y));
        chk("stall_tag", 64'(res_tag), 64'(prev_e.tag));
      end
      if (res_valid && res_ready) begin
        chk("result_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("res_y", 64'(res_y), 64'(e.y));
          chk("res_tag", 64'(res_tag), 64'(e.tag));
        end
        got.push_back('{y: res_y, tag: res_tag});
      end
      prev_stall = res_valid && !res_ready;
      prev_e     = '{y: res_y, tag: res_tag};
    end
  end

  task automatic step(input logic v, input logic [31:0] x, input logic [5:0] t, input logic rr);
    @(posedge clk);
    #1;
    req_valid = v;
    req_x     = x;
    req_tag   = t;
    res_ready = rr;
  endtask

  task automatic wait_mon();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      wait_mon();
      if (!busy && sb.size() == 0) break;
    end
    chk(tag, 64'(k < 300), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   a0;
    logic seen;

    xs[0] = 32'hFFFF_FFFF; ys[0] = 32'hBF80_0000;
    xs[1] = 32'h0000_0000; ys[1] = 32'h0000_0000;
    xs[2] = 32'h0000_0003; ys[2] = 32'h4040_0000;
    xs[3] = 32'h8000_0000; ys[3] = 32'hCF00_0000;

    // Reset state
    repeat (3) @(posedge clk);
    wait_mon();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_mon();
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // Single request latency
    got.delete();
    step(1'b1, 32'd1, 6'd5, 1'b1);
    wait_mon();
    chk("single_accept", 64'(req_ready), 64'd1);
    step(1'b0, 32'd0, 6'd0, 1'b1);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      wait_mon();
      lat++;
      if (res_valid) break;
    end
    chk("single_latency", 64'(lat), 64'd4);
    chk("single_y", 64'(res_y), 64'h3F80_0000);
    chk("single_tag", 64'(res_tag), 64'd5);
    wait_mon();
    chk("single_busy_after", 64'(busy), 64'd0);

    // Back-to-back conversion values
    got.delete();
    for (int i = 0; i < 4; i++) step(1'b1, xs[i], 6'(i), 1'b1);
    step(1'b0, 32'd0, 6'd0, 1'b1);
    wait_drain("b2b_drain");
    chk("b2b_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("b2b_y", 64'(got[i].y), 64'(ys[i]));
      chk("b2b_tag", 64'(got[i].tag), 64'(i));
    end

    // Fill with consumer stalled, then drain
    got.delete();
    a0 = n_acc;
    for (int i = 0; i < 20; i++) step(1'b1, 32'(100 + i), 6'(i), 1'b0);
    wait_mon();
    chk("fill_accepts", 64'(n_acc - a0), 64'd8);
    chk("fill_ready_low", 64'(req_ready), 64'd0);
    step(1'b0, 32'd0, 6'd0, 1'b1);
    wait_drain("fill_drain");
    chk("fill_drained", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("fill_order_tag", 64'(got[i].tag), 64'(i));
      chk("fill_order_y", 64'(got[i].y), 64'(itof(32'(100 + i))));
    end

    // Continuous stream
    got.delete();
    a0 = n_acc;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, $urandom, 6'(i), 1'b1);
      wait_mon();
      chk("stream_ready", 64'(req_ready), 64'd1);
    end
    chk("stream_accepts", 64'(n_acc - a0), 64'd100);
    step(1'b0, 32'd0, 6'd0, 1'b1);
    wait_drain("stream_drain");
    chk("stream_results", 64'(got.size()), 64'd100);

    // Random valid/ready traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(1, 0)), $urandom, 6'($urandom), 1'($urandom_range(1, 0)));
    step(1'b0, 32'd0, 6'd0, 1'b1);
    wait_drain("random_drain");
    chk("random_sb_empty", 64'(sb.size()), 64'd0);

    // Reset with conversions in flight
    step(1'b1, 32'd7, 6'd1, 1'b1);
    step(1'b1, 32'd8, 6'd2, 1'b1);
    step(1'b0, 32'd0, 6'd0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_mon();
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_mon();
    chk("postrst_ready", 64'(req_ready), 64'd1);
    chk("postrst_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      wait_mon();
      seen = seen | res_valid;
    end
    chk("postrst_no_result", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/itof_issue.md
ITOF_ISSUE -- requirements
Module: itof_issue

Interface
REQ-001 SHALL have parameter LAT, default 3, meaning the fixed cvt_x-to-cvt_y latency of the attached int-to-float converter in cycles.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the result FIFO entries; a power of two, at least LAT+1.
REQ-003 SHALL have parameter TAGW, default 6, meaning the destination-register tag width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  conversion request present.
REQ-007 req_ready  out  1  request accepted this cycle if req_valid also high.
REQ-008 req_x  in  32  signed integer operand.
REQ-009 req_tag  in  TAGW  destination tag.
REQ-010 cvt_x  out  32  operand to converter.
REQ-011 cvt_y  in  32  converter result, valid LAT cycles after cvt_x was sampled.
REQ-012 res_valid  out  1  result available at FIFO head.
REQ-013 res_ready  in  1  consumer takes head this cycle.
REQ-014 res_y  out  32  single-precision result.
REQ-015 res_tag  out  TAGW  tag belonging to res_y.
REQ-016 busy  out  1  any conversion in flight or buffered.

Function
REQ-017 SHALL drive cvt_x = req_x combinationally, ungated.
REQ-018 Accept = req_valid && req_ready; SHALL shift {accept, req_tag} into a LAT-deep valid/tag pipeline every cycle, no stall.
REQ-019 SHALL push {cvt_y, tag} into the FIFO in the cycle the pipeline's last stage is valid, so a request accepted in cycle t appears as res_valid in cycle t+LAT+1 (t+4 at default).
REQ-020 req_ready SHALL be 1 iff (FIFO count + valid bits in pipeline) < DEPTH; SHALL NOT depend combinationally on res_ready or req_valid.
REQ-021 FIFO SHALL never overflow; a push into a full FIFO is a design error, flagged by a bench assertion.
REQ-022 res_valid = (count != 0); res_y/res_tag SHALL come from registered FIFO storage at the head, stable while res_valid && !res_ready.
REQ-023 Pop = res_valid && res_ready; pop on empty SHALL be impossible by construction.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-026 Results SHALL leave in acceptance order (strict FIFO).
REQ-027 With res_ready held 1 and DEPTH >= LAT+2, SHALL sustain one accept per cycle.
REQ-028 busy = (pipeline valid bits != 0) || (count != 0).

Reset
REQ-029 While rst is high: req_ready=0, res_valid=0, busy=0; pipeline valid bits, pointers, count cleared.
REQ-030 Reset mid-operation SHALL discard all in-flight and buffered results; none SHALL appear after release.
REQ-031 req_ready SHALL be 1 in the first cycle after rst deasserts; FIFO data and tags need no reset.
REQ-032 The integrator SHALL hold the converter in reset (active-low input tied to ~rst) on the same clock.

Structure
REQ-033 Shared package fpu_pkg SHALL hold ITOF_LAT=3 and TAGW default; LAT defaults from ITOF_LAT.
REQ-034 The FIFO SHALL be a sub-module fifo_sync (parameters WIDTH, DEPTH; push, pop, full, empty, count).
REQ-035 The valid/tag pipeline and credit logic SHALL live in itof_issue; the converter is instantiated by the parent, not inside.

Verification
REQ-036 Single request x=1, tag=5, res_ready=1 -> res_valid exactly 4 cycles later, res_y=0x3F800000, res_tag=5, busy low next cycle.
REQ-037 Requests x=-1, 0, 3, 0x80000000 back-to-back -> results 0xBF800000, 0x00000000, 0x40400000, 0xCF000000 in order.
REQ-038 res_ready=0, req_valid held 1 -> exactly 8 accepts, req_ready low thereafter; raising res_ready drains 8 results in order with outputs stable while stalled.
REQ-039 Continuous stream of 100 requests, res_ready=1 -> 100 accepts in 100 consecutive cycles, 100 in-order results, no FIFO overflow.
REQ-040 Random res_ready toggling with random req_valid -> scoreboard match of every tag/value, count never exceeds 8.
REQ-041 Two requests in flight, rst pulsed one cycle -> no res_valid after release, busy=0, req_ready=1 next cycle.
